// File: rtl/conv_mul_share_arbiter.sv
// Round-robin sharing of one external unsigned multiplier among NUM_REQ requesters.
// A tag pipeline matched to the multiplier latency steers each product back to its owner.
module conv_mul_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int A_WIDTH     = 8,
    parameter int B_WIDTH     = 14,
    parameter int P_WIDTH     = 21,
    parameter int MUL_LATENCY = 0
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [NUM_REQ*P_WIDTH-1:0]   rsp_p,
    output logic [A_WIDTH-1:0]           mul_din0,
    output logic [B_WIDTH-1:0]           mul_din1,
    input  logic [P_WIDTH-1:0]           mul_dout,
    output logic                         busy
);

    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STAGES = MUL_LATENCY + 1;

    logic [NUM_REQ-1:0] outstanding;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] cap_mask;
    logic [NUM_REQ-1:0] rsp_hs;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    grant_id;
    logic               grant_vld;
    logic [A_WIDTH-1:0] sel_a;
    logic [B_WIDTH-1:0] sel_b;
    logic [STAGES-1:0]  vld_p;
    logic [ID_W-1:0]    id_p [STAGES];

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int idx;
        idx       = 0;
        eligible  = req_valid & ~outstanding;
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!grant_vld && eligible[idx]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        grant = '0;
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vld && (grant_id == ID_W'(i))) begin
                grant[i] = 1'b1;
                sel_a    = req_a[i*A_WIDTH +: A_WIDTH];
                sel_b    = req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
    end

    always_comb begin
        cap_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cap_mask[i] = vld_p[STAGES-1] && (id_p[STAGES-1] == ID_W'(i));
        end
    end

    // No handshake can complete while reset is held.
    assign req_ready = ap_rst ? '0 : grant;
    assign rsp_hs    = rsp_valid & rsp_ready;
    assign busy      = |outstanding;

    // Stage p0: issue; credits, pointer and tag valids.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            outstanding <= '0;
            ptr         <= ID_W'(NUM_REQ - 1);
            vld_p       <= '0;
            rsp_valid   <= '0;
        end else begin
            outstanding <= (outstanding & ~rsp_hs) | grant;
            rsp_valid   <= (rsp_valid & ~rsp_hs) | cap_mask;
            if (grant_vld) begin
                ptr <= grant_id;
            end
            vld_p[0] <= grant_vld;
            for (int s = 1; s < STAGES; s++) begin
                vld_p[s] <= vld_p[s-1];
            end
        end
    end

    // Tag ids are only meaningful alongside vld_p, so they carry no reset.
    always_ff @(posedge ap_clk) begin
        id_p[0] <= grant_id;
        for (int s = 1; s < STAGES; s++) begin
            id_p[s] <= id_p[s-1];
        end
    end

    // Stage p0 operands out to the multiplier; final stage captures the product.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            mul_din0 <= '0;
            mul_din1 <= '0;
            rsp_p    <= '0;
        end else begin
            if (grant_vld) begin
                mul_din0 <= sel_a;
                mul_din1 <= sel_b;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cap_mask[i]) begin
                    rsp_p[i*P_WIDTH +: P_WIDTH] <= mul_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_mul_share_arbiter.sv
// Bench for conv_mul_share_arbiter: two instances (latency 0 and 3), each with a
// behavioural multiplier, checked by directed scenarios and a transaction-level model.
module tb_conv_mul_share_arbiter;
    localparam int NR = 4;
    localparam int AW = 8;
    localparam int BW = 14;
    localparam int PW = 21;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic [NR-1:0]    req_valid [2];
    logic [NR-1:0]    req_ready [2];
    logic [NR*AW-1:0] req_a     [2];
    logic [NR*BW-1:0] req_b     [2];
    logic [NR-1:0]    rsp_valid [2];
    logic [NR-1:0]    rsp_ready [2];
    logic [NR*PW-1:0] rsp_p     [2];
    logic [AW-1:0]    din0      [2];
    logic [BW-1:0]    din1      [2];
    logic [PW-1:0]    dout      [2];
    logic             busy      [2];

    conv_mul_share_arbiter #(.NUM_REQ(NR), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .MUL_LATENCY(0)) u0 (
        .ap_clk(clk), .ap_rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_a(req_a[0]), .req_b(req_b[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_p(rsp_p[0]), .mul_din0(din0[0]), .mul_din1(din1[0]), .mul_dout(dout[0]), .busy(busy[0]));

    conv_mul_share_arbiter #(.NUM_REQ(NR), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .MUL_LATENCY(3)) u1 (
        .ap_clk(clk), .ap_rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_a(req_a[1]), .req_b(req_b[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_p(rsp_p[1]), .mul_din0(din0[1]), .mul_din1(din1[1]), .mul_dout(dout[1]), .busy(busy[1]));

    // Behavioural multipliers: combinational, and three register stages.
    logic [PW-1:0] mst [3];
    assign dout[0] = PW'(32'(din0[0]) * 32'(din1[0]));
    always @(posedge clk) begin
        mst[0] <= PW'(32'(din0[1]) * 32'(din1[1]));
        mst[1] <= mst[0];
        mst[2] <= mst[1];
    end
    assign dout[1] = mst[2];

    // Transaction model: each accepted op completes 1+L edges after issue.
    logic [NR-1:0] m_out  [2];
    logic [NR-1:0] m_rv   [2];
    logic [NR-1:0] m_pend [2];
    int            m_ptr  [2];
    int            m_cyc  [2];
    int            m_due  [2][NR];
    logic [PW-1:0] m_prod [2][NR];
    logic [PW-1:0] m_rp   [2][NR];
    logic [AW-1:0] m_d0   [2];
    logic [BW-1:0] m_d1   [2];

    function automatic int model_grant(input logic [NR-1:0] v, input logic [NR-1:0] o, input int p);
        for (int k = 1; k <= NR; k++) begin
            int j;
            j = (p + k) % NR;
            if (v[j] && !o[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_out[d] <= '0; m_rv[d] <= '0; m_pend[d] <= '0;
                m_ptr[d] <= NR - 1; m_cyc[d] <= 0; m_d0[d] <= '0; m_d1[d] <= '0;
                for (int i = 0; i < NR; i++) m_rp[d][i] <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_cyc[d] <= m_cyc[d] + 1;
                for (int i = 0; i < NR; i++) begin
                    if (m_rv[d][i] && rsp_ready[d][i]) begin
                        m_rv[d][i]  <= 1'b0;
                        m_out[d][i] <= 1'b0;
                    end
                    if (m_pend[d][i] && m_due[d][i] == m_cyc[d]) begin
                        m_rv[d][i]   <= 1'b1;
                        m_rp[d][i]   <= m_prod[d][i];
                        m_pend[d][i] <= 1'b0;
                    end
                    if (model_grant(req_valid[d], m_out[d], m_ptr[d]) == i) begin
                        m_out[d][i]  <= 1'b1;
                        m_ptr[d]     <= i;
                        m_d0[d]      <= req_a[d][i*AW +: AW];
                        m_d1[d]      <= req_b[d][i*BW +: BW];
                        m_pend[d][i] <= 1'b1;
                        m_due[d][i]  <= m_cyc[d] + 1 + 3 * d;
                        m_prod[d][i] <= PW'(32'(req_a[d][i*AW +: AW]) * 32'(req_b[d][i*BW +: BW]));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset(input int d);
        req_valid[d] = '1;
        #1;
        checks++; if (rsp_valid[d] !== '0) begin fails++; $display("FAIL reset_rsp_valid d=%0d got %h exp 0", d, rsp_valid[d]); end
        checks++; if (rsp_p[d] !== '0) begin fails++; $display("FAIL reset_rsp_p d=%0d got %h exp 0", d, rsp_p[d]); end
        checks++; if (din0[d] !== '0 || din1[d] !== '0) begin fails++; $display("FAIL reset_din d=%0d got %h/%h exp 0/0", d, din0[d], din1[d]); end
        checks++; if (busy[d] !== 1'b0) begin fails++; $display("FAIL reset_busy d=%0d got %b exp 0", d, busy[d]); end
        checks++; if (req_ready[d] !== '0) begin fails++; $display("FAIL reset_req_ready d=%0d got %b exp 0", d, req_ready[d]); end
        req_valid[d] = '0;
    endtask

    task automatic test_single_op(input int d);
        int L = 3 * d;
        rsp_ready[d] = '0; req_a[d] = '0; req_b[d] = '0;
        req_a[d][0 +: AW] = AW'(200); req_b[d][0 +: BW] = BW'(10000);
        req_valid[d] = 4'b0001;
        #1;
        checks++; if (req_ready[d] !== 4'b0001) begin fails++; $display("FAIL single_grant d=%0d got %b exp 0001", d, req_ready[d]); end
        tick();
        checks++; if (din0[d] !== AW'(200) || din1[d] !== BW'(10000)) begin fails++; $display("FAIL single_din d=%0d got %0d/%0d exp 200/10000", d, din0[d], din1[d]); end
        checks++; if (req_ready[d] !== 4'b0000 || busy[d] !== 1'b1) begin fails++; $display("FAIL single_outstanding d=%0d got rdy %b busy %b exp 0000 1", d, req_ready[d], busy[d]); end
        checks++; if (rsp_valid[d] !== 4'b0000) begin fails++; $display("FAIL single_early d=%0d got %b exp 0000", d, rsp_valid[d]); end
        for (int c = 0; c < L; c++) begin
            tick();
            checks++; if (rsp_valid[d] !== 4'b0000) begin fails++; $display("FAIL single_latency d=%0d got %b exp 0000", d, rsp_valid[d]); end
        end
        tick();
        checks++; if (rsp_valid[d] !== 4'b0001) begin fails++; $display("FAIL single_rsp_valid d=%0d got %b exp 0001", d, rsp_valid[d]); end
        checks++; if (rsp_p[d][0 +: PW] !== PW'(2000000)) begin fails++; $display("FAIL single_rsp_p d=%0d got %0d exp 2000000", d, rsp_p[d][0 +: PW]); end
        repeat (2) begin
            tick();
            checks++; if (req_ready[d] !== 4'b0000 || rsp_valid[d] !== 4'b0001 || rsp_p[d][0 +: PW] !== PW'(2000000)) begin
                fails++; $display("FAIL single_hold d=%0d got rdy %b vld %b p %0d exp 0000 0001 2000000", d, req_ready[d], rsp_valid[d], rsp_p[d][0 +: PW]);
            end
        end
        rsp_ready[d][0] = 1'b1;
        tick();
        checks++; if (rsp_valid[d] !== 4'b0000 || busy[d] !== 1'b0) begin fails++; $display("FAIL single_consume d=%0d got vld %b busy %b exp 0000 0", d, rsp_valid[d], busy[d]); end
        checks++; if (req_ready[d] !== 4'b0001) begin fails++; $display("FAIL single_regrant d=%0d got %b exp 0001", d, req_ready[d]); end
        checks++; if (rsp_p[d][0 +: PW] !== PW'(2000000)) begin fails++; $display("FAIL single_retain d=%0d got %0d exp 2000000", d, rsp_p[d][0 +: PW]); end
        req_valid[d] = '0; rsp_ready[d] = '0;
    endtask

    task automatic test_contention(input int d);
        int L = 3 * d;
        logic [NR-1:0] er, ev;
        int c;
        do_reset();
        rsp_ready[d] = '1;
        for (int i = 0; i < NR; i++) begin
            req_a[d][i*AW +: AW] = AW'(i + 1);
            req_b[d][i*BW +: BW] = BW'(100);
        end
        req_valid[d] = '1;
        for (int t = 0; t <= L + 6; t++) begin
            if (t >= 1 && t <= 4) req_valid[d][t-1] = 1'b0;
            #1;
            er = '0; if (t < 4) er[t] = 1'b1;
            c = t - 2 - L;
            ev = '0; if (c >= 0 && c < 4) ev[c] = 1'b1;
            checks++; if (req_ready[d] !== er) begin fails++; $display("FAIL contention_grant d=%0d t=%0d got %b exp %b", d, t, req_ready[d], er); end
            checks++; if (rsp_valid[d] !== ev) begin fails++; $display("FAIL contention_rsp d=%0d t=%0d got %b exp %b", d, t, rsp_valid[d], ev); end
            if (c >= 0 && c < 4) begin
                checks++; if (rsp_p[d][c*PW +: PW] !== PW'(100 * (c + 1))) begin fails++; $display("FAIL contention_p d=%0d slot=%0d got %0d exp %0d", d, c, rsp_p[d][c*PW +: PW], 100 * (c + 1)); end
            end
            tick();
        end
        checks++; if (busy[d] !== 1'b0) begin fails++; $display("FAIL contention_busy d=%0d got %b exp 0", d, busy[d]); end
    endtask

    task automatic test_round_robin(input int d);
        int L = 3 * d;
        rsp_ready[d] = '1;
        req_valid[d] = 4'b0100;
        #1;
        checks++; if (req_ready[d] !== 4'b0100) begin fails++; $display("FAIL rr_setup d=%0d got %b exp 0100", d, req_ready[d]); end
        tick();
        req_valid[d] = '0;
        repeat (L + 3) tick();
        req_valid[d] = 4'b1001;
        #1;
        checks++; if (req_ready[d] !== 4'b1000) begin fails++; $display("FAIL rr_first d=%0d got %b exp 1000", d, req_ready[d]); end
        tick();
        checks++; if (req_ready[d] !== 4'b0001) begin fails++; $display("FAIL rr_second d=%0d got %b exp 0001", d, req_ready[d]); end
        tick();
        req_valid[d] = '0;
        repeat (L + 4) tick();
        checks++; if (busy[d] !== 1'b0) begin fails++; $display("FAIL rr_drain d=%0d got %b exp 0", d, busy[d]); end
    endtask

    task automatic test_backpressure(input int d);
        int L = 3 * d;
        int g0 = 0, g1 = 0, g2 = 0;
        logic seen = 1'b0, found = 1'b0;
        for (int i = 0; i < NR; i++) begin
            req_a[d][i*AW +: AW] = AW'(i + 3);
            req_b[d][i*BW +: BW] = BW'(1000 + i);
        end
        rsp_ready[d] = 4'b1101;
        req_valid[d] = 4'b0111;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (req_ready[d][0]) g0++;
            if (req_ready[d][1]) g1++;
            if (req_ready[d][2]) g2++;
            if (seen || rsp_valid[d][1]) begin
                checks++; if (rsp_valid[d][1] !== 1'b1 || rsp_p[d][1*PW +: PW] !== PW'(4004)) begin
                    fails++; $display("FAIL bp_hold d=%0d c=%0d got vld %b p %0d exp 1 4004", d, c, rsp_valid[d][1], rsp_p[d][1*PW +: PW]);
                end
                seen = 1'b1;
            end
            tick();
        end
        checks++; if (seen !== 1'b1) begin fails++; $display("FAIL bp_result d=%0d got %b exp 1", d, seen); end
        checks++; if (g1 != 1) begin fails++; $display("FAIL bp_single_grant d=%0d got %0d exp 1", d, g1); end
        checks++; if (g0 < 3 || g2 < 3) begin fails++; $display("FAIL bp_others_served d=%0d got %0d/%0d exp >=3/>=3", d, g0, g2); end
        rsp_ready[d][1] = 1'b1;
        #1;
        checks++; if (req_ready[d][1] !== 1'b0) begin fails++; $display("FAIL bp_no_bypass d=%0d got %b exp 0", d, req_ready[d][1]); end
        tick();
        for (int c = 0; c < 8; c++) begin
            if (!found) begin
                #1;
                if (req_ready[d][1]) found = 1'b1;
                else tick();
            end
        end
        checks++; if (found !== 1'b1) begin fails++; $display("FAIL bp_regrant d=%0d got %b exp 1", d, found); end
        req_valid[d] = '0; rsp_ready[d] = '1;
        repeat (L + 4) tick();
        checks++; if (busy[d] !== 1'b0) begin fails++; $display("FAIL bp_drain d=%0d got %b exp 0", d, busy[d]); end
    endtask

    task automatic test_width(input int d);
        int L = 3 * d;
        rsp_ready[d] = 4'b0100;
        req_a[d][2*AW +: AW] = AW'(255);
        req_b[d][2*BW +: BW] = BW'(16383);
        req_valid[d] = 4'b0100;
        #1;
        checks++; if (req_ready[d] !== 4'b0100) begin fails++; $display("FAIL width_grant d=%0d got %b exp 0100", d, req_ready[d]); end
        tick();
        req_valid[d] = '0;
        repeat (L + 1) tick();
        checks++; if (rsp_valid[d][2] !== 1'b1 || rsp_p[d][2*PW +: PW] !== PW'(2080513)) begin
            fails++; $display("FAIL width_product d=%0d got vld %b p %0d exp 1 2080513", d, rsp_valid[d][2], rsp_p[d][2*PW +: PW]);
        end
        tick();
        checks++; if (rsp_valid[d] !== 4'b0000 || rsp_p[d][2*PW +: PW] !== PW'(2080513) || busy[d] !== 1'b0) begin
            fails++; $display("FAIL width_retain d=%0d got vld %b p %0d busy %b exp 0000 2080513 0", d, rsp_valid[d], rsp_p[d][2*PW +: PW], busy[d]);
        end
        rsp_ready[d] = '0;
    endtask

    task automatic test_random(input int d);
        int L = 3 * d;
        int eg;
        logic [NR-1:0] er, last;
        logic [NR*PW-1:0] ep;
        last = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[d][i] || last[i]) begin
                    req_valid[d][i] = ($urandom_range(0, 2) != 0);
                    req_a[d][i*AW +: AW] = AW'($urandom_range(0, 255));
                    req_b[d][i*BW +: BW] = BW'($urandom_range(0, 16383));
                end
                rsp_ready[d][i] = ($urandom_range(0, 3) != 0);
            end
            #1;
            eg = model_grant(req_valid[d], m_out[d], m_ptr[d]);
            er = '0; if (eg >= 0) er[eg] = 1'b1;
            for (int i = 0; i < NR; i++) ep[i*PW +: PW] = m_rp[d][i];
            checks++; if (req_ready[d] !== er) begin fails++; $display("FAIL rand_ready d=%0d cyc=%0d got %b exp %b", d, cyc, req_ready[d], er); end
            checks++; if (rsp_valid[d] !== m_rv[d]) begin fails++; $display("FAIL rand_rsp_valid d=%0d cyc=%0d got %b exp %b", d, cyc, rsp_valid[d], m_rv[d]); end
            checks++; if (rsp_p[d] !== ep) begin fails++; $display("FAIL rand_rsp_p d=%0d cyc=%0d got %h exp %h", d, cyc, rsp_p[d], ep); end
            checks++; if (din0[d] !== m_d0[d] || din1[d] !== m_d1[d]) begin fails++; $display("FAIL rand_din d=%0d cyc=%0d got %0d/%0d exp %0d/%0d", d, cyc, din0[d], din1[d], m_d0[d], m_d1[d]); end
            checks++; if (busy[d] !== (|m_out[d])) begin fails++; $display("FAIL rand_busy d=%0d cyc=%0d got %b exp %b", d, cyc, busy[d], |m_out[d]); end
            last = er;
            tick();
        end
        req_valid[d] = '0; rsp_ready[d] = '1;
        repeat (L + 4) tick();
        rsp_ready[d] = '0;
    endtask

    task automatic test_async_reset(input int d);
        int L = 3 * d;
        rsp_ready[d] = '1;
        req_valid[d] = 4'b0111;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        req_valid[d] = 4'b1111;
        #1;
        checks++; if (rsp_valid[d] !== '0 || rsp_p[d] !== '0) begin fails++; $display("FAIL areset_rsp d=%0d got %b %h exp 0 0", d, rsp_valid[d], rsp_p[d]); end
        checks++; if (din0[d] !== '0 || din1[d] !== '0) begin fails++; $display("FAIL areset_din d=%0d got %h/%h exp 0/0", d, din0[d], din1[d]); end
        checks++; if (busy[d] !== 1'b0 || req_ready[d] !== '0) begin fails++; $display("FAIL areset_ctrl d=%0d got busy %b rdy %b exp 0 0000", d, busy[d], req_ready[d]); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (req_ready[d] !== 4'b0001) begin fails++; $display("FAIL areset_first_grant d=%0d got %b exp 0001", d, req_ready[d]); end
        req_valid[d] = '0;
        for (int c = 0; c < L + 5; c++) begin
            tick();
            checks++; if (rsp_valid[d] !== '0) begin fails++; $display("FAIL areset_stale d=%0d c=%0d got %b exp 0000", d, c, rsp_valid[d]); end
        end
        rsp_ready[d] = '0;
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = '0; rsp_ready[d] = '0; req_a[d] = '0; req_b[d] = '0;
        end
        repeat (2) @(negedge clk);
        test_reset(0);
        test_reset(1);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            test_single_op(d);
            test_contention(d);
            test_round_robin(d);
            test_backpressure(d);
            test_width(d);
            test_random(d);
            test_async_reset(d);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
